// File: rtl/leds_pkg.sv
// rtl/leds_pkg.sv - shared encodings for the LED pattern controller
// Contents: mode encodings, register word indices, CTRL/STATUS bit positions.
package leds_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_MODE_LSB    = 0;
  localparam int CTRL_RUN_BIT     = 2;
  localparam int STATUS_DIR_BIT   = 8;
  localparam int STATUS_PHASE_BIT = 9;
  localparam int STATUS_MODE_LSB  = 16;

endpackage

// File: rtl/leds_tick_gen.sv
// rtl/leds_tick_gen.sv - step prescaler for the LED pattern controller
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   period     : cycles per step (0 behaves as 1), sampled at each reload
//   run        : count enable; counter holds while low
//   restart    : reload the counter this edge
//   tick       : one-cycle step strobe (counter at 0 while running)
module leds_tick_gen
  import leds_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                run,
  input  logic                restart,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] reload;

  // max(period,1)-1: a zero period degenerates to a step every cycle
  assign reload = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick   = run && (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart) begin
      count <= reload;
    end else if (run) begin
      if (count == '0) count <= reload;
      else             count <= count - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/leds_ctrl.sv
// rtl/leds_ctrl.sv - memory-mapped LED pattern controller (static/blink/chase/bounce)
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   sel, we    : zero-wait-state bus select and write strobe
//   addr       : word index (0 CTRL, 1 PATTERN, 2 PERIOD, 3 STATUS)
//   data_i     : write data
//   ready      : equals sel
//   data_o     : combinational read data selected by addr
//   leds       : LED pins, optionally inverted
module leds_ctrl
  import leds_pkg::*;
#(
  parameter int                  NUM_LEDS     = 6,
  parameter int                  PERIOD_W     = 24,
  parameter logic [PERIOD_W-1:0] RESET_PERIOD = 24'd13_500_000,
  parameter bit                  ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  input  logic                we,
  input  logic [1:0]          addr,
  input  logic [31:0]         data_i,
  output logic                ready,
  output logic [31:0]         data_o,
  output logic [NUM_LEDS-1:0] leds
);

  mode_t               mode;
  logic                run;
  logic [NUM_LEDS-1:0] pattern;
  logic [PERIOD_W-1:0] period;
  logic [NUM_LEDS-1:0] led_state;
  logic                phase;
  logic                dir;

  logic wr;
  logic restart;
  logic tick;

  assign wr      = sel && we;
  // CTRL and PATTERN writes resynchronise the animation; PERIOD writes do not
  assign restart = wr && ((addr == ADDR_CTRL) || (addr == ADDR_PATTERN));

  leds_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .period  (period),
    .run     (run),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode      <= MODE_STATIC;
      run       <= 1'b0;
      pattern   <= '0;
      period    <= RESET_PERIOD;
      led_state <= '0;
      phase     <= 1'b0;
      dir       <= 1'b1;
    end else begin
      if (wr) begin
        case (addr)
          ADDR_CTRL: begin
            mode <= mode_t'(data_i[CTRL_MODE_LSB +: 2]);
            run  <= data_i[CTRL_RUN_BIT];
          end
          ADDR_PATTERN: pattern <= data_i[NUM_LEDS-1:0];
          ADDR_PERIOD:  period  <= data_i[PERIOD_W-1:0];
          default: ;
        endcase
      end

      // a restarting write takes priority over a coincident tick
      if (restart) begin
        led_state <= (addr == ADDR_PATTERN) ? data_i[NUM_LEDS-1:0] : pattern;
        phase     <= 1'b0;
        dir       <= 1'b1;
      end else if (tick) begin
        case (mode)
          MODE_STATIC: led_state <= pattern;
          MODE_BLINK: begin
            phase     <= ~phase;
            led_state <= phase ? pattern : '0;
          end
          MODE_CHASE: led_state <= {led_state[NUM_LEDS-2:0], led_state[NUM_LEDS-1]};
          MODE_BOUNCE: begin
            // reverse instead of shifting a set bit off the end
            if (dir) begin
              if (led_state[NUM_LEDS-1]) begin
                dir       <= 1'b0;
                led_state <= led_state >> 1;
              end else begin
                led_state <= led_state << 1;
              end
            end else begin
              if (led_state[0]) begin
                dir       <= 1'b1;
                led_state <= led_state << 1;
              end else begin
                led_state <= led_state >> 1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_o = '0;
    case (addr)
      ADDR_CTRL: begin
        data_o[CTRL_MODE_LSB +: 2] = mode;
        data_o[CTRL_RUN_BIT]       = run;
      end
      ADDR_PATTERN: data_o[NUM_LEDS-1:0] = pattern;
      ADDR_PERIOD:  data_o[PERIOD_W-1:0] = period;
      default: begin
        data_o[NUM_LEDS-1:0]         = led_state;
        data_o[STATUS_DIR_BIT]       = dir;
        data_o[STATUS_PHASE_BIT]     = phase;
        data_o[STATUS_MODE_LSB +: 2] = mode;
      end
    endcase
  end

  assign ready = sel;
  assign leds  = ACTIVE_LOW ? ~led_state : led_state;

endmodule
